wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL take parameter NUM_REQ, default 3: number of writeback requesters, legal range 2..4.
REQ-002 SHALL take parameter DATA_W, default 32: writeback data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester writeback valid.
REQ-006 SHALL have port req_addr  input  5*NUM_REQ  per-requester destination register; slice i is bits [5i+4:5i].
REQ-007 SHALL have port req_data  input  DATA_W*NUM_REQ  per-requester write data; slice i is bits [DATA_W*i+DATA_W-1:DATA_W*i].
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both 1.
REQ-009 SHALL have port rsv_valid  input  1  issue stage reserves a destination register.
REQ-010 SHALL have port rsv_addr  input  5  register being reserved.
REQ-011 SHALL have ports rd_addr_a and rd_addr_b  input  5 each  scoreboard query addresses (rs, rt).
REQ-012 SHALL have ports busy_a and busy_b  output  1 each  the queried register has a pending write.
REQ-013 SHALL have ports rf_we, rf_waddr, rf_wdata  output  1/5/DATA_W  register-file write port.

Function
REQ-014 SHALL compute req_ready combinationally from req_valid and the round-robin pointer: grant the first valid requester at or after the pointer, wrapping modulo NUM_REQ, at most one bit set.
REQ-015 SHALL, on a transfer from requester i, move the pointer to (i+1) mod NUM_REQ; with no transfer, the pointer holds.
REQ-016 SHALL drive req_ready to all zeros when req_valid is zero; ready SHALL NOT depend on any ready-like input (no backpressure from the register file).
REQ-017 SHALL register the winner's address and data: a transfer in cycle N makes rf_we=1 with that address and data during cycle N+1.
REQ-018 SHALL drive rf_we=0 in any cycle that follows a cycle with no transfer.
REQ-019 SHALL, for a transfer to register 0, consume the request and advance the pointer, but keep rf_we=0 in N+1.
REQ-020 SHALL keep a 32-bit busy vector: rsv_valid with a nonzero rsv_addr sets busy[rsv_addr] at the clock edge.
REQ-021 SHALL clear busy[rf_waddr] at the edge ending a cycle in which rf_we=1, i.e. the same edge at which the register file commits the write.
REQ-022 SHALL let set win when a set and a clear target the same register on the same edge.
REQ-023 SHALL hold busy[0]=0 permanently.
REQ-024 SHALL leave busy set (a single bit, not a count) when an already-busy register is reserved again; preventing WAW is the issue stage's responsibility.
REQ-025 SHALL drive busy_a and busy_b combinationally from the registered busy vector (no bypass of the current-cycle set or clear).

Reset
REQ-026 SHALL, while rst_n=0, force pointer=0, busy=0, rf_we=0, rf_waddr=0 and rf_wdata=0, asynchronously.
REQ-027 SHALL drop any transfer in flight when reset asserts mid-operation; the requester that saw ready before reset SHALL re-present after reset.
REQ-028 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place REG_ADDR_W=5 and NUM_REGS=32 in the shared core package; NUM_REQ and DATA_W stay as module parameters.
REQ-030 SHALL implement the round-robin grant in one sub-module rr_arbiter (inputs request and pointer, output one-hot grant); the scoreboard and output register stay inline.

Verification
REQ-031 SHALL cover: all 3 valid continuously with pointer 0 -> grants 0,1,2,0,... on consecutive cycles, rf_we high every cycle from the second onward.
REQ-032 SHALL cover: requester 1 only, addr 7, data 0xDEADBEEF in cycle N -> rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF in cycle N+1, then rf_we=0 in N+2.
REQ-033 SHALL cover: reserve r9, then query rd_addr_a=9 -> busy_a=1 until the edge ending the rf_we cycle for r9, then busy_a=0.
REQ-034 SHALL cover: rsv_addr=5 in the same cycle that rf_we writes r5 -> busy[5] remains 1.
REQ-035 SHALL cover: writeback and reserve to r0 -> request consumed, rf_we=0, busy_a for rd_addr_a=0 stays 0.
REQ-036 SHALL cover: rst_n pulsed low mid-stream with busy=0x0000_0F00 and pointer=2 -> busy=0, pointer=0, rf_we=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared core constants for the writeback arbiter and register scoreboard.
package wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin grant: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Scan priority offsets from the pointer; the first hit wins, later hits are masked.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (!found && request[j] && (j == ((int'(pointer) + k) % int'(NUM_REQ)))) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin choice among requesters, one registered
// register-file write port, and a 32-entry pending-write scoreboard.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [REG_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         rsv_valid,
    input  logic [REG_ADDR_W-1:0]        rsv_addr,
    input  logic [REG_ADDR_W-1:0]        rd_addr_a,
    input  logic [REG_ADDR_W-1:0]        rd_addr_b,
    output logic                         busy_a,
    output logic                         busy_b,
    output logic                         rf_we,
    output logic [REG_ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    grant;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0]     win_data;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0]     rf_wdata_q;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .request (req_valid),
        .pointer (ptr_q),
        .grant   (grant)
    );

    // Grant only ever covers valid requesters, so any grant bit is a transfer.
    assign req_ready = grant;
    assign xfer      = |grant;

    // Mux the winner's payload and compute the pointer just past the winner.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        ptr_d    = ptr_q;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (grant[j]) begin
                win_addr = req_addr[REG_ADDR_W*j +: REG_ADDR_W];
                win_data = req_data[DATA_W*j +: DATA_W];
                ptr_d    = PTR_W'((j + 1) % int'(NUM_REQ));
            end
        end
    end

    // Round-robin pointer advances only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Register the winning write; r0 writes are consumed but never committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= xfer && (win_addr != '0);
            if (xfer) begin
                rf_waddr_q <= win_addr;
                rf_wdata_q <= win_data;
            end
        end
    end

    // Scoreboard update: clear on commit, then set, so a same-edge reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_a   = busy_q[rd_addr_a];
    assign busy_b   = busy_q[rd_addr_b];
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter with a transaction-level reference model.
module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [4:0]      ta [N];
    logic [DW-1:0]   td [N];
    logic [5*N-1:0]  req_addr;
    logic [DW*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rsv_valid;
    logic [4:0]      rsv_addr;
    logic [4:0]      rd_addr_a, rd_addr_b;
    logic            busy_a, busy_b;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [DW-1:0]   rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign req_addr = {ta[2], ta[1], ta[0]};
    assign req_data = {td[2], td[1], td[0]};

    wb_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_ptr;
    bit [31:0]     m_busy, m_busy_next;
    bit            m_we;
    bit [4:0]      m_waddr;
    bit [DW-1:0]   m_wdata;
    int            m_w;
    logic [N-1:0]  exp_ready;

    function automatic int winner(input logic [N-1:0] v, input int p);
        logic [N-1:0] sh;
        for (int k = 0; k < N; k++) begin
            sh = v >> ((p + k) % N);
            if (sh[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    always_comb begin
        m_w       = winner(req_valid, m_ptr);
        exp_ready = '0;
        if (m_w >= 0) exp_ready = N'(1) << m_w;
        m_busy_next = m_busy;
        if (m_we) m_busy_next[m_waddr] = 1'b0;
        if (rsv_valid) m_busy_next[rsv_addr] = 1'b1;
        m_busy_next[0] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   <= 0;
            m_busy  <= '0;
            m_we    <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
        end else begin
            m_busy <= m_busy_next;
            if (m_w >= 0) begin
                m_ptr   <= (m_w + 1) % N;
                m_we    <= (ta[m_w] != 5'd0);
                m_waddr <= ta[m_w];
                m_wdata <= td[m_w];
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_ready", 64'(req_ready), 64'(exp_ready));
            chk("model_rf_we", 64'(rf_we), 64'(m_we));
            if (m_we) begin
                chk("model_rf_waddr", 64'(rf_waddr), 64'(m_waddr));
                chk("model_rf_wdata", 64'(rf_wdata), 64'(m_wdata));
            end
            chk("model_busy_a", 64'(busy_a), 64'(m_busy[rd_addr_a]));
            chk("model_busy_b", 64'(busy_b), 64'(m_busy[rd_addr_b]));
        end else begin
            chk("rst_rf_we", 64'(rf_we), 64'd0);
            chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
            chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; req_valid = '0; rsv_valid = 1'b0; rsv_addr = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        for (int i = 0; i < N; i++) begin ta[i] = '0; td[i] = '0; end
        #3;
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("reset_busy_a", 64'(busy_a), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // All three valid: grants 0,1,2,0 back to back.
        ta[0] = 5'd1; ta[1] = 5'd2; ta[2] = 5'd3;
        td[0] = 32'hA0; td[1] = 32'hA1; td[2] = 32'hA2;
        req_valid = 3'b111;
        #1 chk("rr_first_ready", 64'(req_ready), 64'b001);
        tick();
        chk("rr_ready_1", 64'(req_ready), 64'b010);
        chk("rr_we_1", 64'(rf_we), 64'd1);
        chk("rr_waddr_1", 64'(rf_waddr), 64'd1);
        tick();
        chk("rr_ready_2", 64'(req_ready), 64'b100);
        chk("rr_waddr_2", 64'(rf_waddr), 64'd2);
        tick();
        chk("rr_ready_wrap", 64'(req_ready), 64'b001);
        chk("rr_wdata_3", 64'(rf_wdata), 64'hA2);
        tick();
        chk("rr_waddr_4", 64'(rf_waddr), 64'd1);
        chk("rr_we_4", 64'(rf_we), 64'd1);
        req_valid = '0;
        tick();
        chk("rr_idle_we", 64'(rf_we), 64'd0);

        // Single requester 1 write to r7.
        ta[1] = 5'd7; td[1] = 32'hDEADBEEF; req_valid = 3'b010;
        #1 chk("single_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        chk("single_we", 64'(rf_we), 64'd1);
        chk("single_waddr", 64'(rf_waddr), 64'd7);
        chk("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        tick();
        chk("single_we_off", 64'(rf_we), 64'd0);

        // Reserve r9, hold busy until its write commits.
        rsv_valid = 1'b1; rsv_addr = 5'd9; rd_addr_a = 5'd9;
        #1 chk("rsv_no_bypass", 64'(busy_a), 64'd0);
        tick();
        rsv_valid = 1'b0;
        chk("rsv9_busy", 64'(busy_a), 64'd1);
        tick(); tick();
        chk("rsv9_hold", 64'(busy_a), 64'd1);
        ta[0] = 5'd9; req_valid = 3'b001;
        #1 chk("wrap_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        chk("wb9_we", 64'(rf_we), 64'd1);
        chk("wb9_busy_still", 64'(busy_a), 64'd1);
        tick();
        chk("wb9_busy_clear", 64'(busy_a), 64'd0);

        // Reserve r5 again on the edge its write commits: set wins.
        rsv_valid = 1'b1; rsv_addr = 5'd5; rd_addr_b = 5'd5;
        tick();
        rsv_valid = 1'b0;
        chk("rsv5_busy", 64'(busy_b), 64'd1);
        ta[1] = 5'd5; req_valid = 3'b010;
        tick();
        req_valid = '0;
        chk("wb5_waddr", 64'(rf_waddr), 64'd5);
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        tick();
        rsv_valid = 1'b0;
        chk("set_wins", 64'(busy_b), 64'd1);
        tick();
        chk("set_wins_hold", 64'(busy_b), 64'd1);

        // Writeback and reserve to r0.
        ta[2] = 5'd0; td[2] = 32'h55; req_valid = 3'b100;
        rsv_valid = 1'b1; rsv_addr = 5'd0; rd_addr_a = 5'd0;
        #1 chk("r0_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = '0; rsv_valid = 1'b0;
        chk("r0_no_we", 64'(rf_we), 64'd0);
        chk("r0_busy", 64'(busy_a), 64'd0);
        ta[0] = 5'd1; ta[1] = 5'd2; ta[2] = 5'd3; req_valid = 3'b111;
        #1 chk("r0_ptr_advanced", 64'(req_ready), 64'b001);
        req_valid = '0;

        // Build busy=0x0F00, pointer=2, then reset mid-cycle.
        for (int r = 8; r < 12; r++) begin
            rsv_valid = 1'b1; rsv_addr = 5'(r);
            tick();
        end
        rsv_valid = 1'b0; rd_addr_a = 5'd9; rd_addr_b = 5'd11;
        ta[1] = 5'd4; td[1] = 32'h1234; req_valid = 3'b010;
        tick();
        chk("pre_rst_we", 64'(rf_we), 64'd1);
        req_valid = 3'b111;
        #1 chk("pre_rst_ready", 64'(req_ready), 64'b100);
        chk("pre_rst_busy_a", 64'(busy_a), 64'd1);
        chk("pre_rst_busy_b", 64'(busy_b), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_ready_ptr0", 64'(req_ready), 64'b001);
        chk("rst_we_now", 64'(rf_we), 64'd0);
        chk("rst_waddr_now", 64'(rf_waddr), 64'd0);
        chk("rst_wdata_now", 64'(rf_wdata), 64'd0);
        chk("rst_busy_a_now", 64'(busy_a), 64'd0);
        chk("rst_busy_b_now", 64'(busy_b), 64'd0);
        tick();
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 64'(req_ready), 64'b001);
        tick();
        chk("post_rst_we", 64'(rf_we), 64'd1);
        chk("post_rst_waddr", 64'(rf_waddr), 64'd1);
        req_valid = '0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
